// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter: FSM state encoding,
// requester IDs and the sizing helper for the optional access timeout counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_e;

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  // Counter must be able to hold TIMEOUT_CYCLES itself.
  function automatic int timeout_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_picker.sv
// Combinational round-robin picker: returns the first requester set after
// last_grant (wrapping), so the previous owner has the lowest priority.
module rr_priority_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_req
);

  localparam int ID_W = $clog2(NUM_REQ);

  int   idx;
  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between NUM_REQ requesters, one access
// at a time. Define MEM_ARB_TIMEOUT_EN to abort accesses stuck waiting on mem_ready.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_err,
  output logic [DATA_W-1:0]          req_rdata,
  output logic [ADDR_W-1:0]          addr_bus,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic                       mem_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mem_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Request inputs are only looked at in IDLE; everything the bus needs is latched at grant.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          state_d = ARB_ACCESS;
          owner_d = winner;
          we_d    = req_we[winner];
          addr_d  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[int'(winner)*DATA_W +: DATA_W];
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ARB_ACCESS: begin
        if (mem_ready) begin
          state_d = ARB_DONE;
          if (!we_q) rdata_d = mem_rdata;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ARB_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ARB_DONE: begin
        last_grant_d = owner_q;
        state_d      = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  always_comb begin
    req_done = '0;
    if (state_q == ARB_DONE) req_done[owner_q] = 1'b1;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  assign req_err = err_q ? req_done : '0;
`else
  assign req_err = '0;
`endif

  assign req_rdata = rdata_q;
  assign addr_bus  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = (state_q == ARB_ACCESS) && !we_q;
  assign mem_write = (state_q == ARB_ACCESS) && we_q;
  assign grant_id  = owner_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (2 requesters, TIMEOUT_CYCLES = 8).
// The timeout scenario only runs when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic [DATA_W-1:0]         req_rdata;
  logic [ADDR_W-1:0]         addr_bus;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_read;
  logic                      mem_write;
  logic                      mem_ready;
  logic [0:0]                grant_id;
  logic                      busy;

  int checkCount;
  int errorCount;

  mem_bus_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .addr_bus  (addr_bus),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_ready (mem_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic valid, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[id]               = valid;
    req_we[id]                  = we;
    req_addr[id*ADDR_W +: ADDR_W] = addr;
    req_wdata[id*DATA_W +: DATA_W] = wdata;
  endtask

  // Steps negedges until a done pulse appears, counting strobe-high cycles on the way.
  task automatic waitForDone(input int budget, output int strobeCycles, output logic [1:0] doneVec);
    logic seen;
    strobeCycles = 0;
    doneVec      = '0;
    seen         = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) strobeCycles++;
      if (req_done != '0) begin
        doneVec = req_done;
        seen    = 1'b1;
      end
    end
    if (!seen) checkOutput("done_wait_budget", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          strobes;
    logic [1:0]  doneVec;
    logic        addrMoved;
    logic [1:0]  expDone;

    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_busy",     64'(busy),      64'd0);
    checkOutput("rst_mem_read", 64'(mem_read),  64'd0);
    checkOutput("rst_mem_write",64'(mem_write), 64'd0);
    checkOutput("rst_done",     64'(req_done),  64'd0);
    checkOutput("rst_err",      64'(req_err),   64'd0);
    checkOutput("rst_rdata",    64'(req_rdata), 64'd0);
    checkOutput("rst_addr",     64'(addr_bus),  64'd0);
    checkOutput("rst_grant",    64'(grant_id),  64'd0);

    // Single read by requester 0
    $display("[TB] single read");
    rst_n     = 1'b1;
    mem_rdata = 32'h0050_0093;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_8000, 32'h0);
    @(negedge clk);
    checkOutput("rd_mem_read",  64'(mem_read),  64'd1);
    checkOutput("rd_mem_write", 64'(mem_write), 64'd0);
    checkOutput("rd_addr",      64'(addr_bus),  64'h8000);
    checkOutput("rd_busy",      64'(busy),      64'd1);
    checkOutput("rd_done_early",64'(req_done),  64'd0);
    @(negedge clk);
    checkOutput("rd_done",      64'(req_done),  64'b01);
    checkOutput("rd_rdata",     64'(req_rdata), 64'h0050_0093);
    checkOutput("rd_strobe_off",64'(mem_read),  64'd0);
    checkOutput("rd_err",       64'(req_err),   64'd0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rd_done_once", 64'(req_done),  64'd0);
    checkOutput("rd_idle",      64'(busy),      64'd0);

    // Write by requester 1
    $display("[TB] single write");
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_9000, 32'hCAFE_F00D);
    @(negedge clk);
    checkOutput("wr_mem_write", 64'(mem_write), 64'd1);
    checkOutput("wr_mem_read",  64'(mem_read),  64'd0);
    checkOutput("wr_addr",      64'(addr_bus),  64'h9000);
    checkOutput("wr_wdata",     64'(mem_wdata), 64'hCAFE_F00D);
    checkOutput("wr_grant",     64'(grant_id),  64'd1);
    @(negedge clk);
    checkOutput("wr_done",      64'(req_done),  64'b10);
    checkOutput("wr_strobe_off",64'(mem_write), 64'd0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Contention from reset: grant order alternates starting with requester 0
    $display("[TB] contention");
    rst_n = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_A000, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_B000, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      waitForDone(10, strobes, doneVec);
      expDone = (t % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput($sformatf("cont_done_%0d", t),  64'(doneVec),  64'(expDone));
      checkOutput($sformatf("cont_grant_%0d", t), 64'(grant_id), 64'(t % 2));
      checkOutput($sformatf("cont_strobes_%0d", t), 64'(strobes), 64'd1);
      if (t == 0) begin
        @(negedge clk);
        checkOutput("cont_idle_gap", 64'(busy), 64'd0);
      end
    end
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    // Wait states: mem_ready low for 5 ACCESS cycles, late address change ignored
    $display("[TB] wait states");
    mem_ready = 1'b0;
    mem_rdata = 32'h1111_2222;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_8004, 32'h0);
    strobes   = 0;
    addrMoved = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (mem_read) strobes++;
      if (addr_bus !== 32'h0000_8004) addrMoved = 1'b1;
      if (req_done != '0) checkOutput("ws_done_early", 64'(req_done), 64'd0);
      if (i == 2) req_addr[0 +: ADDR_W] = 32'hDEAD_0000;
      if (i == 6) mem_ready = 1'b1;
    end
    checkOutput("ws_strobe_cycles", 64'(strobes),   64'd6);
    checkOutput("ws_addr_stable",   64'(addrMoved), 64'd0);
    @(negedge clk);
    checkOutput("ws_done",   64'(req_done),  64'b01);
    checkOutput("ws_rdata",  64'(req_rdata), 64'h1111_2222);
    checkOutput("ws_err",    64'(req_err),   64'd0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("ws_done_once", 64'(req_done), 64'd0);

    // Reset in the middle of an access by requester 1
    $display("[TB] reset during access");
    mem_ready = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_C000, 32'h0);
    @(negedge clk);
    checkOutput("rstacc_grant",    64'(grant_id), 64'd1);
    checkOutput("rstacc_mem_read", 64'(mem_read), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstacc_strobe_rd", 64'(mem_read),  64'd0);
    checkOutput("rstacc_strobe_wr", 64'(mem_write), 64'd0);
    checkOutput("rstacc_busy",      64'(busy),      64'd0);
    checkOutput("rstacc_no_done",   64'(req_done),  64'd0);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_800C, 32'h0);
    @(negedge clk);
    checkOutput("rstacc_first_grant", 64'(grant_id), 64'd0);
    checkOutput("rstacc_first_addr",  64'(addr_bus), 64'h800C);
    @(negedge clk);
    checkOutput("rstacc_done0",  64'(req_done),  64'b01);
    checkOutput("rstacc_rdata0", 64'(req_rdata), 64'hA5A5_A5A5);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    waitForDone(10, strobes, doneVec);
    checkOutput("rstacc_done1", 64'(doneVec), 64'b10);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: mem_ready never rises, access aborts after 8 ACCESS cycles
    $display("[TB] timeout");
    mem_ready = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_8008, 32'h0);
    waitForDone(20, strobes, doneVec);
    checkOutput("to_strobe_cycles", 64'(strobes),   64'd8);
    checkOutput("to_done",          64'(doneVec),   64'b01);
    checkOutput("to_err",           64'(req_err),   64'b01);
    checkOutput("to_rdata",         64'(req_rdata), 64'd0);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("to_err_cleared", 64'(req_err), 64'd0);
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_D000, 32'h0);
    waitForDone(10, strobes, doneVec);
    checkOutput("to_next_done",  64'(doneVec),   64'b10);
    checkOutput("to_next_err",   64'(req_err),   64'd0);
    checkOutput("to_next_rdata", 64'(req_rdata), 64'h1234_5678);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
